// File: rtl/exp_mu_table_gen.sv
// rtl/exp_mu_table_gen.sv - multi-channel S0*exp(t*mu) drift table generator
module exp_mu_table_gen #(
  parameter int NCH     = 4,
  parameter int LOGT    = 9,
  parameter int EXP_LAT = 4,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW     = CW + LOGT
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              iStart,
  input  logic [LOGT-1:0]   iTmin,
  input  logic [LOGT-1:0]   iTmax,
  input  logic [NCH*18-1:0] iMu,
  input  logic [NCH*18-1:0] iS,
  output logic [17:0]       oTmu,
  output logic              oTmuValid,
  input  logic [21:0]       iExp,
  output logic [17:0]       oData,
  output logic [AW-1:0]     oAddr,
  output logic              oValid,
  output logic              oBusy,
  output logic              oDone,
  output logic              oOvf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              busy_nxt;

  logic [LOGT-1:0]   tmin_r;
  logic [LOGT-1:0]   tmax_r;
  logic [LOGT-1:0]   t_cnt;
  logic [CW-1:0]     c_cnt;
  logic [17:0]       mu_r [NCH];
  logic [17:0]       s_r  [NCH];

  // v_d[0]/a_d[0] belong to the oTmu stage; index EXP_LAT lines up with iExp
  logic [EXP_LAT:0]  v_d;
  logic [AW-1:0]     a_d [EXP_LAT+1];

  logic              start_acc;
  logic              issue;
  logic              last_issue;
  logic              drain_end;
  logic [17+LOGT:0]  prod_a;
  logic              ovf_a;
  logic [CW-1:0]     c_sel;
  logic [35:0]       prod_c;
  logic              sat_c;
  logic              unused_bits;

  assign start_acc  = (state == IDLE) && iStart;
  assign issue      = (state == RUN);
  assign last_issue = issue && (c_cnt == CW'(NCH - 1)) && (t_cnt == tmax_r);
  // Entries leave the delay line back to back, so the tail is the last valid
  // stage with an empty stage behind it.
  assign drain_end  = v_d[EXP_LAT] && !v_d[EXP_LAT-1];

  assign prod_a      = (18+LOGT)'(mu_r[c_cnt]) * (18+LOGT)'(t_cnt);
  assign ovf_a       = issue && (prod_a[17+LOGT:18] != '0);
  assign c_sel       = a_d[EXP_LAT][AW-1:LOGT];
  assign prod_c      = 36'(iExp[21:4]) * 36'(s_r[c_sel]);
  assign sat_c       = (prod_c[35:31] != 5'd0);
  assign oTmuValid   = v_d[0];
  assign unused_bits = ^{iExp[3:0], prod_c[12:0]};

  // Next-state logic; busy covers the first issue cycle through the last oValid
  always_comb begin
    state_nxt = state;
    busy_nxt  = 1'b0;
    case (state)
      IDLE:    if (iStart) state_nxt = (iTmin > iTmax) ? DONE : RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == RUN) || (state_nxt == DRAIN) || (state == DRAIN);
  end

  // State register with registered busy and one-cycle done pulse
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      state <= state_nxt;
      oBusy <= busy_nxt;
      oDone <= (state == DONE);
    end
  end

  // Run parameters latched on start; {c, t} walk with t wrapping per channel
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tmin_r <= '0;
      tmax_r <= '0;
      t_cnt  <= '0;
      c_cnt  <= '0;
      for (int i = 0; i < NCH; i++) begin
        mu_r[i] <= '0;
        s_r[i]  <= '0;
      end
    end else if (start_acc) begin
      tmin_r <= iTmin;
      tmax_r <= iTmax;
      t_cnt  <= iTmin;
      c_cnt  <= '0;
      for (int i = 0; i < NCH; i++) begin
        mu_r[i] <= iMu[18*i +: 18];
        s_r[i]  <= iS[18*i +: 18];
      end
    end else if (issue) begin
      // equality test before increment keeps tmax = all-ones from wrapping t
      if (t_cnt == tmax_r) begin
        t_cnt <= tmin_r;
        c_cnt <= c_cnt + CW'(1);
      end else begin
        t_cnt <= t_cnt + LOGT'(1);
      end
    end
  end

  // Stage A (t*mu to the exp core) and the {c, t} delay line matching its latency
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      oTmu <= '0;
      v_d  <= '0;
      for (int i = 0; i <= EXP_LAT; i++) a_d[i] <= '0;
    end else begin
      oTmu   <= prod_a[17:0];
      v_d[0] <= issue;
      a_d[0] <= {c_cnt, t_cnt};
      for (int i = 1; i <= EXP_LAT; i++) begin
        v_d[i] <= v_d[i-1];
        a_d[i] <= a_d[i-1];
      end
    end
  end

  // Stage C: S0 of the carried channel times exp, saturating, plus sticky overflow
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      oValid <= 1'b0;
      oData  <= '0;
      oAddr  <= '0;
      oOvf   <= 1'b0;
    end else begin
      oValid <= v_d[EXP_LAT];
      if (v_d[EXP_LAT]) begin
        oAddr <= a_d[EXP_LAT];
        oData <= sat_c ? 18'h3FFFF : prod_c[30:13];
      end
      if (start_acc) begin
        oOvf <= 1'b0;
      end else if (ovf_a || (v_d[EXP_LAT] && sat_c)) begin
        oOvf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/exp_mu_table_gen.md
# exp_mu_table_gen

Multi-channel, run-time-ranged generator of the drift table S0_c · exp(t · mu_c) for every channel c in 0..NCH-1 and every t in [tmin, tmax]. It writes one table entry per cycle into the downstream path-table RAM, with a combined {channel, t} address. It is the parametrised successor of the single-asset fixed-range drift generator, and sits between the parameter registers and the Monte-Carlo path RAM. It drives the shared Exponential core through an issue/return port pair with fixed latency, and adds product saturation, an overflow flag, a busy status and a start handshake.

## Interface
- NCH, 4: number of channels; must be at least 1. CW = max(1, clog2(NCH)).
- LOGT, 9: width of the time index t.
- EXP_LAT, 4: cycles from oTmu to the matching iExp; must be at least 1.
- CLK in 1: clock; all logic is on the rising edge.
- RSTn in 1: asynchronous, active-low reset.
- iStart in 1: start request; sampled only in IDLE.
- iTmin in LOGT: first t, unsigned; latched on start.
- iTmax in LOGT: last t, unsigned; latched on start.
- iMu in NCH*18: packed mu, channel c at [18c+17:18c]; format 0.18 unsigned; latched on start.
- iS in NCH*18: packed S0; format 4.14 unsigned; latched on start.
- oTmu out 18: t·mu to the Exponential core; format 0.18.
- oTmuValid out 1: oTmu is valid this cycle.
- iExp in 22: exp(oTmu) returned by the core; format 4.18.
- oData out 18: table entry; format 3.15.
- oAddr out CW+LOGT: {c, t} of oData.
- oValid out 1: write strobe for oData/oAddr.
- oBusy out 1: run in progress.
- oDone out 1: one-cycle completion pulse.
- oOvf out 1: sticky overflow flag; cleared on start.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, iStart=1:
  - latch iTmin, iTmax, iMu, iS; clear oOvf; c=0, t=tmin.
  - If tmin>tmax, go to DONE (empty run, no oValid). Otherwise go to RUN.
- RUN: issue (c, t) every cycle.
  - t increments; when t==tmax, t returns to tmin and c increments.
  - After issuing (NCH-1, tmax), go to DRAIN.
- DRAIN: no issue. Go to DONE in the cycle the last oValid is asserted.
- DONE: assert oDone for one cycle, then go to IDLE.
- oBusy=1 in RUN and DRAIN.
- iStart is ignored outside IDLE; no queuing.
- Stage A (issue +1): tmu = low 18 bits of mu_c × t (18×LOGT unsigned product).
  - If any higher product bit is set, oOvf←1 and tmu wraps (no saturation).
  - Output on oTmu, oTmuValid=1.
- Stage B: the block carries {c, t} alongside the exponential in a valid/address delay line of depth EXP_LAT.
- Stage C (product): p = iExp[21:4] (4.14) × S0_c (4.14) gives 36 bits in 8.28 format.
  - If p[35:31]≠0: oData=18'h3FFFF and oOvf←1.
  - Otherwise oData=p[30:13].
- The channel mu and S0 used in Stage C are those of the issuing channel; the values are selected from the carried c, not the live counter.
- Reset (RSTn=0, any time, including mid-run):
  - state←IDLE.
  - oTmuValid, oValid, oBusy, oDone, oOvf←0.
  - oTmu, oData, oAddr←0.
  - Delay line cleared; iExp returning for pre-reset issues is discarded.

## Timing
- Issue of (c, t) in cycle k produces:
  - oTmu/oTmuValid in cycle k+1;
  - iExp sampled at cycle k+1+EXP_LAT;
  - oData/oAddr/oValid in cycle k+2+EXP_LAT.
- Total latency is EXP_LAT+2; throughput is one entry per cycle, with no gaps within a run.
- First issue is in the cycle after iStart is accepted. oBusy rises in that same cycle.
- The run produces NCH·(tmax−tmin+1) consecutive oValid cycles.
- oDone is asserted in the cycle after the last oValid; oBusy falls in that cycle.
- Empty run: oDone is asserted two cycles after iStart; oBusy stays 0.
- oOvf is valid from the cycle after the offending stage and holds until the next accepted start.
- tmax = 2^LOGT−1 must not wrap t: the end-of-row test uses equality before increment.

## Test plan
- NCH=4, tmin=0, tmax=2, mu=0, S0=18'h04000, core model returns 22'h040000:
  - 12 consecutive oValid, each with oData=18'h08000.
  - oAddr sequence 0,1,2,512,513,514,1024,… ({c,t}).
  - oDone one cycle after the last oValid.
- mu_1=18'h00100, t=5 → oTmu=18'h00500; the returned exp is aligned to the c=1, t=5 output at latency EXP_LAT+2.
- S0=18'h20000 (8.0), iExp=22'h080000 (2.0) → oData=18'h3FFFF, oOvf=1. oOvf clears on the next start.
- iTmin=10, iTmax=9 → no oValid, oBusy stays 0, oDone pulses 2 cycles after iStart. iStart during RUN is ignored, with an unchanged entry count.
- RSTn low mid-RUN → all outputs 0 within the same cycle. A new start after release gives a clean full run with no stale oValid.
- tmin=tmax=511, LOGT=9 → exactly NCH entries, each with t=511, and the run terminates.
